// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared UART definitions (FSM state encodings, line levels, baud divisor rounding)
package uart_tx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam logic MARK  = 1'b1;
  localparam logic SPACE = 1'b0;
  function automatic int baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte source handshake; master drives tx_data/tx_valid, slave (transmitter) drives tx_ready
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: reloadable bit-period down-counter
// Ports: clkin, manurst (async active-low), load_i (restart a bit period), bit_end_o (last cycle of a bit)
module uart_baud_gen #(
  parameter int BAUD_DIV = 521
) (
  input  logic clkin,
  input  logic manurst,
  input  logic load_i,
  output logic bit_end_o
);
  localparam int W = $clog2(BAUD_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  // Saturates at zero instead of wrapping, so an unloaded counter just parks.
  always_comb cnt_d = load_i ? W'(BAUD_DIV - 1) : (cnt_q == '0 ? '0 : cnt_q - W'(1));
  always_ff @(posedge clkin or negedge manurst)
    if (!manurst) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  assign bit_end_o = cnt_q == '0;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 UART transmitter (8E1/8E2 when UART_TX_PARITY_EN is defined)
// Ports: clkin, manurst (async active-low), bus (slave: tx_data/tx_valid/tx_ready),
//        tx_busy (frame in progress), tx (registered pad output, inverted when TX_INVERT=1)
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ  = 10_000_000,
  parameter int BAUD      = 19200,
  parameter int STOP_BITS = 1,
  parameter bit TX_INVERT = 1'b1
) (
  input  logic      clkin,
  input  logic      manurst,
  uart_tx_if.slave  bus,
  output logic      tx_busy,
  output logic      tx
);
  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  state_e     state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_q;
  logic       stop_q;
  logic       ready_q;
  logic       busy_q;
  logic       tx_q;
  logic       bit_end;
  logic       accept;
`ifdef UART_TX_PARITY_EN
  logic       par_q;
`endif
  assign accept = bus.tx_valid && ready_q;
  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clkin    (clkin),
    .manurst  (manurst),
    .load_i   (accept || (busy_q && bit_end)),
    .bit_end_o(bit_end)
  );
  always_ff @(posedge clkin or negedge manurst)
    if (!manurst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      tx_q    <= MARK ^ TX_INVERT;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= !accept;
          if (accept) begin
            state_q <= START;
            busy_q  <= 1'b1;
            shift_q <= bus.tx_data;
            tx_q    <= SPACE ^ TX_INVERT;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^bus.tx_data;
`endif
          end
        end
        START: if (bit_end) begin
          state_q <= DATA;
          tx_q    <= shift_q[0] ^ TX_INVERT;
          shift_q <= shift_q >> 1;
        end
        DATA: if (bit_end) begin
          if (bit_q == 3'd7) begin
            bit_q  <= '0;
            stop_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            state_q <= PARITY;
            tx_q    <= par_q ^ TX_INVERT;
`else
            state_q <= STOP;
            tx_q    <= MARK ^ TX_INVERT;
`endif
          end else begin
            bit_q   <= bit_q + 3'd1;
            tx_q    <= shift_q[0] ^ TX_INVERT;
            shift_q <= shift_q >> 1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          state_q <= STOP;
          tx_q    <= MARK ^ TX_INVERT;
        end
`endif
        STOP: if (bit_end) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            stop_q  <= 1'b0;
          end else stop_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.tx_ready = ready_q;
  assign tx_busy      = busy_q;
  assign tx           = tx_q;
endmodule
